ps2_ascii_stream: RTL and testbench
===================================

Name: ps2_ascii_stream

Overview:
- Sequential successor to the keyboard scan-code lookup.
- Consumes the raw PS/2 Set-2 byte stream from the PS/2 receiver, one byte per `code_valid` strobe.
- Tracks the make/break/extended prefixes, Shift and Caps Lock state.
- Emits case-correct ASCII characters through a parametrised ready/valid output FIFO feeding the display/text buffer.

Parameters:
- FIFO_DEPTH, 8, number of ASCII entries buffered; power of 2, min 2.
- COUNT_W, 8, width of emitted-character counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- code_valid  in  1  one-cycle strobe: code_in holds a received scan byte
- code_in  in  8  Set-2 scan byte
- ascii_ready  in  1  consumer accepts the head entry
- ascii_valid  out  1  FIFO non-empty
- ascii_out  out  8  FIFO head character
- shift_on  out  1  either Shift key currently held
- caps_on  out  1  Caps Lock latch
- overflow  out  1  sticky: a character was dropped because the FIFO was full
- char_count  out  COUNT_W  characters written into the FIFO, wraps modulo 2^COUNT_W

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: ascii_valid=0, ascii_out=0x00, shift_on=0, caps_on=0, overflow=0, char_count=0, FIFO empty, parser in IDLE, held-key registers cleared.
- Parser states: IDLE, EXT (after 0xE0), BRK (after 0xF0), EXT_BRK (after 0xE0 0xF0).
- Transitions, evaluated only on cycles with code_valid=1:
  - IDLE: 0xE0 -> EXT; 0xF0 -> BRK; any other byte is a make code, processed, stay IDLE.
  - EXT: 0xF0 -> EXT_BRK; any other byte is discarded -> IDLE.
  - BRK: byte is a break code -> IDLE.
  - EXT_BRK: byte discarded -> IDLE.
- Shift: left Shift 0x12 and right Shift 0x59 tracked separately (held bit set on make, cleared on break). shift_on = OR of the two held bits.
- Caps Lock 0x58: caps_on toggles on a make only when caps is not already held (caps_held flag cleared on break). Typematic repeats never re-toggle.
- Make-code translation (written to the FIFO on the same edge the byte is sampled); unlisted codes produce nothing:
  - Letters, same 26 codes as the existing table (0x1C=A ... 0x1A=Z): uppercase 0x41-0x5A when shift_on XOR caps_on, else lowercase 0x61-0x7A.
  - Top-row digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to '0'-'9'. With shift_on they map to ')','!','@','#','$','%','^','&','*','('. Caps has no effect.
  - Keypad digits 0x70,0x69,0x72,0x7A,0x6B,0x73,0x74,0x6C,0x75,0x7D map to '0'-'9' regardless of modifiers.
  - 0x29 -> 0x20 (space); 0x5A -> 0x0D (enter); 0x66 -> 0x08 (backspace).
- Translation uses the shift/caps state before the current byte's update.
- FIFO:
  - Write on translation hit; char_count increments on each accepted write.
  - Read when ascii_valid & ascii_ready.
  - Latency: a character written at edge N appears on ascii_out with ascii_valid=1 after edge N. There is no same-cycle bypass.
  - Full and no read: the write is dropped, overflow set, char_count unchanged.
  - Full with a simultaneous read: the write is accepted.
  - Empty with a simultaneous write: the write is accepted and ascii_valid rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - ascii_out is held stable while ascii_valid=1 and ascii_ready=0.
- Reset mid-sequence (e.g. between 0xF0 and the break byte): parser returns to IDLE, FIFO contents are discarded, and the pending byte is lost.
- code_valid while rst=1 is ignored.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- Defined: the last non-modifier make code is kept as held_code (cleared by its break or by reset). A make identical to held_code is dropped, so typematic repeat yields a single character per press. A different make replaces held_code.
- Undefined: every make code is translated, so a held key produces one character per typematic repeat.

Test Plan:
- Reset, then bytes 0x1C, 0xF0, 0x1C with ascii_ready=1 -> exactly one char 0x61 ('a'); char_count=1; parser in IDLE.
- 0x12, 0x1C, 0xF0, 0x12, 0x1C -> chars 0x41 then 0x61; shift_on high only between the 0x12 make and its break.
- 0x58, 0x58, 0xF0, 0x58, then 0x12, 0x32 -> caps_on=1 after the first 0x58 (the repeat does not toggle it); output 0x62 ('b', because shift XOR caps = 0).
- 0xE0, 0x70, then 0xE0, 0xF0, 0x70, then 0x70 -> only one char 0x30; extended bytes produce nothing.
- ascii_ready=0, FIFO_DEPTH=8, ten makes of 0x29 -> eight 0x20 entries, overflow=1, char_count=8. Then assert ascii_ready with a concurrent write -> both the read and the write happen that cycle.
- With PS2_REPEAT_FILTER_EN: 0x1D, 0x1D, 0x1D, 0xF0, 0x1D, 0x1D -> two 0x77 ('w'). Without the macro -> four 0x77.

Source files
------------

// File: rtl/ps2_ascii_stream.sv
// -----------------------------------------------------------------------------
// ps2_ascii_stream
//
// Turns the raw PS/2 Set-2 byte stream from the PS/2 receiver into a stream of
// case-correct ASCII characters. A small parser follows the 0xE0 (extended)
// and 0xF0 (break) prefixes. Modifier tracking covers left/right Shift and the
// Caps Lock latch. Translated make codes go into a ready/valid FIFO that feeds
// the display/text buffer.
//
// Parameters
//   FIFO_DEPTH : number of ASCII entries buffered (power of 2, >= 2)
//   COUNT_W    : width of the emitted-character counter
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   code_valid  in   one-cycle strobe, code_in holds a received scan byte
//   code_in     in   Set-2 scan byte
//   ascii_ready in   consumer accepts the head entry
//   ascii_valid out  FIFO non-empty
//   ascii_out   out  FIFO head character (0x00 while empty)
//   shift_on    out  either Shift key currently held
//   caps_on     out  Caps Lock latch
//   overflow    out  sticky, a character was dropped because the FIFO was full
//   char_count  out  characters written into the FIFO, wraps modulo 2^COUNT_W
//
// Build option
//   PS2_REPEAT_FILTER_EN : when defined, the last non-modifier make code is
//   remembered. A typematic repeat of that code is dropped, so a held key
//   yields one character per press. When undefined, every make is translated.
//
// Output handshake: an entry transfers on any rising edge where ascii_valid
// and ascii_ready are both high. ascii_out holds its value while ascii_valid=1
// and ascii_ready=0. A character written on edge N is visible after edge N.
// There is no same-cycle bypass from code_in to ascii_out.
// -----------------------------------------------------------------------------
module ps2_ascii_stream #(
    parameter int FIFO_DEPTH = 8,
    parameter int COUNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               code_valid,
    input  logic [7:0]         code_in,
    input  logic               ascii_ready,
    output logic               ascii_valid,
    output logic [7:0]         ascii_out,
    output logic               shift_on,
    output logic               caps_on,
    output logic               overflow,
    output logic [COUNT_W-1:0] char_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_L = FIFO_DEPTH[PTR_W:0];

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    // -------------------------------------------------------------------------
    // Prefix parser
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   make_evt;    // code_in is a plain (non-extended) make code
    logic   break_evt;   // code_in is a plain (non-extended) break code

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the parser only moves on received bytes
    always_comb begin
        state_next = state;
        if (code_valid) begin
            case (state)
                IDLE: begin
                    if (code_in == CODE_EXT) begin
                        state_next = EXT;
                    end else if (code_in == CODE_BRK) begin
                        state_next = BRK;
                    end
                end
                EXT: begin
                    state_next = (code_in == CODE_BRK) ? EXT_BRK : IDLE;
                end
                BRK:     state_next = IDLE;
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode: extended makes/breaks are swallowed here
    always_comb begin
        make_evt  = 1'b0;
        break_evt = 1'b0;
        if (code_valid) begin
            case (state)
                IDLE:    make_evt  = (code_in != CODE_EXT) && (code_in != CODE_BRK);
                BRK:     break_evt = 1'b1;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Modifier tracking
    // -------------------------------------------------------------------------
    logic lshift_held;
    logic rshift_held;
    logic caps_held;

    assign shift_on = lshift_held | rshift_held;

    always_ff @(posedge clk) begin
        if (rst) begin
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            caps_held   <= 1'b0;
            caps_on     <= 1'b0;
        end else if (make_evt) begin
            case (code_in)
                CODE_LSHIFT: lshift_held <= 1'b1;
                CODE_RSHIFT: rshift_held <= 1'b1;
                CODE_CAPS: begin
                    // Only the first make of a press toggles, typematic
                    // repeats arrive while caps_held is already set.
                    if (!caps_held) begin
                        caps_on <= ~caps_on;
                    end
                    caps_held <= 1'b1;
                end
                default: ;
            endcase
        end else if (break_evt) begin
            case (code_in)
                CODE_LSHIFT: lshift_held <= 1'b0;
                CODE_RSHIFT: rshift_held <= 1'b0;
                CODE_CAPS:   caps_held   <= 1'b0;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Typematic repeat filter
    // -------------------------------------------------------------------------
    logic repeat_drop;

`ifdef PS2_REPEAT_FILTER_EN
    logic       held_valid;
    logic [7:0] held_code;
    logic       is_modifier;

    assign is_modifier = (code_in == CODE_LSHIFT) || (code_in == CODE_RSHIFT) ||
                         (code_in == CODE_CAPS);
    assign repeat_drop = held_valid && (code_in == held_code);

    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= 1'b0;
            held_code  <= 8'h00;
        end else if (make_evt && !is_modifier) begin
            held_valid <= 1'b1;
            held_code  <= code_in;
        end else if (break_evt && held_valid && (code_in == held_code)) begin
            held_valid <= 1'b0;
        end
    end
`else
    assign repeat_drop = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Make-code translation (uses modifier state from before this byte)
    // -------------------------------------------------------------------------
    logic       letter_hit;
    logic [4:0] letter_idx;
    logic       digit_hit;
    logic       keypad_hit;
    logic [3:0] digit_idx;
    logic       misc_hit;
    logic [7:0] misc_char;
    logic [7:0] shifted_sym;
    logic       xlat_hit;
    logic [7:0] xlat_char;

    always_comb begin
        letter_hit = 1'b0;
        letter_idx = 5'd0;
        digit_hit  = 1'b0;
        keypad_hit = 1'b0;
        digit_idx  = 4'd0;
        misc_hit   = 1'b0;
        misc_char  = 8'h00;
        case (code_in)
            // Letters A..Z
            8'h1C: begin letter_hit = 1'b1; letter_idx = 5'd0;  end
            8'h32: begin letter_hit = 1'b1; letter_idx = 5'd1;  end
            8'h21: begin letter_hit = 1'b1; letter_idx = 5'd2;  end
            8'h23: begin letter_hit = 1'b1; letter_idx = 5'd3;  end
            8'h24: begin letter_hit = 1'b1; letter_idx = 5'd4;  end
            8'h2B: begin letter_hit = 1'b1; letter_idx = 5'd5;  end
            8'h34: begin letter_hit = 1'b1; letter_idx = 5'd6;  end
            8'h33: begin letter_hit = 1'b1; letter_idx = 5'd7;  end
            8'h43: begin letter_hit = 1'b1; letter_idx = 5'd8;  end
            8'h3B: begin letter_hit = 1'b1; letter_idx = 5'd9;  end
            8'h42: begin letter_hit = 1'b1; letter_idx = 5'd10; end
            8'h4B: begin letter_hit = 1'b1; letter_idx = 5'd11; end
            8'h3A: begin letter_hit = 1'b1; letter_idx = 5'd12; end
            8'h31: begin letter_hit = 1'b1; letter_idx = 5'd13; end
            8'h44: begin letter_hit = 1'b1; letter_idx = 5'd14; end
            8'h4D: begin letter_hit = 1'b1; letter_idx = 5'd15; end
            8'h15: begin letter_hit = 1'b1; letter_idx = 5'd16; end
            8'h2D: begin letter_hit = 1'b1; letter_idx = 5'd17; end
            8'h1B: begin letter_hit = 1'b1; letter_idx = 5'd18; end
            8'h2C: begin letter_hit = 1'b1; letter_idx = 5'd19; end
            8'h3C: begin letter_hit = 1'b1; letter_idx = 5'd20; end
            8'h2A: begin letter_hit = 1'b1; letter_idx = 5'd21; end
            8'h1D: begin letter_hit = 1'b1; letter_idx = 5'd22; end
            8'h22: begin letter_hit = 1'b1; letter_idx = 5'd23; end
            8'h35: begin letter_hit = 1'b1; letter_idx = 5'd24; end
            8'h1A: begin letter_hit = 1'b1; letter_idx = 5'd25; end
            // Top-row digits 0..9
            8'h45: begin digit_hit = 1'b1; digit_idx = 4'd0; end
            8'h16: begin digit_hit = 1'b1; digit_idx = 4'd1; end
            8'h1E: begin digit_hit = 1'b1; digit_idx = 4'd2; end
            8'h26: begin digit_hit = 1'b1; digit_idx = 4'd3; end
            8'h25: begin digit_hit = 1'b1; digit_idx = 4'd4; end
            8'h2E: begin digit_hit = 1'b1; digit_idx = 4'd5; end
            8'h36: begin digit_hit = 1'b1; digit_idx = 4'd6; end
            8'h3D: begin digit_hit = 1'b1; digit_idx = 4'd7; end
            8'h3E: begin digit_hit = 1'b1; digit_idx = 4'd8; end
            8'h46: begin digit_hit = 1'b1; digit_idx = 4'd9; end
            // Keypad digits 0..9
            8'h70: begin keypad_hit = 1'b1; digit_idx = 4'd0; end
            8'h69: begin keypad_hit = 1'b1; digit_idx = 4'd1; end
            8'h72: begin keypad_hit = 1'b1; digit_idx = 4'd2; end
            8'h7A: begin keypad_hit = 1'b1; digit_idx = 4'd3; end
            8'h6B: begin keypad_hit = 1'b1; digit_idx = 4'd4; end
            8'h73: begin keypad_hit = 1'b1; digit_idx = 4'd5; end
            8'h74: begin keypad_hit = 1'b1; digit_idx = 4'd6; end
            8'h6C: begin keypad_hit = 1'b1; digit_idx = 4'd7; end
            8'h75: begin keypad_hit = 1'b1; digit_idx = 4'd8; end
            8'h7D: begin keypad_hit = 1'b1; digit_idx = 4'd9; end
            // Space, enter, backspace
            8'h29: begin misc_hit = 1'b1; misc_char = 8'h20; end
            8'h5A: begin misc_hit = 1'b1; misc_char = 8'h0D; end
            8'h66: begin misc_hit = 1'b1; misc_char = 8'h08; end
            default: ;
        endcase
    end

    // Shifted top-row symbols, indexed by digit value
    always_comb begin
        case (digit_idx)
            4'd0:    shifted_sym = 8'h29; // )
            4'd1:    shifted_sym = 8'h21; // !
            4'd2:    shifted_sym = 8'h40; // @
            4'd3:    shifted_sym = 8'h23; // #
            4'd4:    shifted_sym = 8'h24; // $
            4'd5:    shifted_sym = 8'h25; // %
            4'd6:    shifted_sym = 8'h5E; // ^
            4'd7:    shifted_sym = 8'h26; // &
            4'd8:    shifted_sym = 8'h2A; // *
            4'd9:    shifted_sym = 8'h28; // (
            default: shifted_sym = 8'h00;
        endcase
    end

    always_comb begin
        xlat_hit  = letter_hit | digit_hit | keypad_hit | misc_hit;
        xlat_char = misc_char;
        if (letter_hit) begin
            xlat_char = ((shift_on ^ caps_on) ? 8'h41 : 8'h61) + {3'b000, letter_idx};
        end else if (digit_hit) begin
            xlat_char = shift_on ? shifted_sym : (8'h30 + {4'b0000, digit_idx});
        end else if (keypad_hit) begin
            xlat_char = 8'h30 + {4'b0000, digit_idx};
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fill;
    logic             full;
    logic             wr_req;
    logic             do_write;
    logic             do_read;

    assign full        = (fill == DEPTH_L);
    assign ascii_valid = (fill != '0);
    // Gate the head so an empty FIFO shows 0x00 rather than stale data
    assign ascii_out   = ascii_valid ? mem[rd_ptr] : 8'h00;

    assign wr_req   = make_evt && xlat_hit && !repeat_drop;
    assign do_read  = ascii_valid && ascii_ready;
    // A full FIFO still takes the write when the head leaves on the same edge
    assign do_write = wr_req && (!full || do_read);

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= xlat_char;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            overflow   <= 1'b0;
            char_count <= '0;
        end else begin
            if (do_write) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                char_count <= char_count + COUNT_W'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_write, do_read})
                2'b10:   fill <= fill + (PTR_W + 1)'(1);
                2'b01:   fill <= fill - (PTR_W + 1)'(1);
                default: ;
            endcase
            if (wr_req && !do_write) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_ascii_stream.sv
// -----------------------------------------------------------------------------
// tb_ps2_ascii_stream
//
// Directed scenarios followed by randomized byte traffic. A reference model
// tracks prefixes, modifiers and the character queue in plain behavioural
// terms, and every cycle's outputs are compared against it. Characters the
// consumer actually accepts are also logged so directed scenarios can check
// the delivered text against fixed expectations.
// -----------------------------------------------------------------------------
module tb_ps2_ascii_stream;

    localparam int DEPTH = 8;
    localparam int CW    = 8;

    // ------------------------------------------------------------------ clock/reset
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          code_valid = 1'b0;
    logic [7:0]    code_in = 8'h00;
    logic          ascii_ready = 1'b0;
    logic          ascii_valid;
    logic [7:0]    ascii_out;
    logic          shift_on;
    logic          caps_on;
    logic          overflow;
    logic [CW-1:0] char_count;

    always #5 clk = ~clk;

    ps2_ascii_stream #(.FIFO_DEPTH(DEPTH), .COUNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .code_valid  (code_valid),
        .code_in     (code_in),
        .ascii_ready (ascii_ready),
        .ascii_valid (ascii_valid),
        .ascii_out   (ascii_out),
        .shift_on    (shift_on),
        .caps_on     (caps_on),
        .overflow    (overflow),
        .char_count  (char_count)
    );

    // ------------------------------------------------------------------ lookup tables
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] digit_syms   [10] = '{")", "!", "@", "#", "$", "%", "^", "&", "*", "("};
    logic [7:0] keypad_codes [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                      8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    // Random traffic pool: weighted toward prefixes and modifiers
    logic [7:0] pool [24] = '{8'h1C, 8'h1D, 8'h32, 8'h1A, 8'h44, 8'h45, 8'h16, 8'h3E,
                              8'h70, 8'h7D, 8'h29, 8'h5A, 8'h66, 8'h12, 8'h59, 8'h58,
                              8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h12, 8'h05, 8'h76, 8'h1D};

    // ------------------------------------------------------------------ reference model
    logic [CW-1:0] exp_q[$];     // characters expected to be in the FIFO
    logic [7:0]    got_q[$];     // characters the consumer accepted
    bit            m_ext, m_brk, m_lsh, m_rsh, m_caps, m_caps_held, m_ovf;
    bit            m_held_valid;
    logic [7:0]    m_held_code;
    logic [CW-1:0] m_count;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [8:0] ref_char(logic [7:0] code, bit sh, bit cp);
        for (int i = 0; i < 26; i++)
            if (code == letter_codes[i])
                return {1'b1, (sh ^ cp) ? 8'(65 + i) : 8'(97 + i)};
        for (int i = 0; i < 10; i++)
            if (code == digit_codes[i])
                return {1'b1, sh ? digit_syms[i] : 8'(48 + i)};
        for (int i = 0; i < 10; i++)
            if (code == keypad_codes[i])
                return {1'b1, 8'(48 + i)};
        if (code == 8'h29) return {1'b1, 8'h20};
        if (code == 8'h5A) return {1'b1, 8'h0D};
        if (code == 8'h66) return {1'b1, 8'h08};
        return 9'h000;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        {m_ext, m_brk, m_lsh, m_rsh, m_caps, m_caps_held, m_ovf, m_held_valid} = '0;
        m_held_code = 8'h00;
        m_count = '0;
    endtask

    task automatic model_press(input logic [7:0] c, output bit wr, output logic [7:0] ch);
        logic [8:0] r;
        bit modifier;
        r  = ref_char(c, m_lsh | m_rsh, m_caps);
        wr = r[8];
        ch = r[7:0];
        modifier = (c == 8'h12) || (c == 8'h59) || (c == 8'h58);
`ifdef PS2_REPEAT_FILTER_EN
        if (m_held_valid && c == m_held_code) wr = 0;
        if (!modifier) begin
            m_held_valid = 1;
            m_held_code  = c;
        end
`endif
        if (c == 8'h12) m_lsh = 1;
        if (c == 8'h59) m_rsh = 1;
        if (c == 8'h58) begin
            if (!m_caps_held) m_caps = !m_caps;
            m_caps_held = 1;
        end
    endtask

    task automatic model_release(input logic [7:0] c);
        if (c == 8'h12) m_lsh = 0;
        if (c == 8'h59) m_rsh = 0;
        if (c == 8'h58) m_caps_held = 0;
`ifdef PS2_REPEAT_FILTER_EN
        if (m_held_valid && c == m_held_code) m_held_valid = 0;
`endif
    endtask

    task automatic model_cycle(input bit v, input logic [7:0] c, input bit r);
        bit rd, wr;
        logic [7:0] ch;
        rd = r && (exp_q.size() > 0);
        wr = 0;
        ch = 8'h00;
        if (v) begin
            if (m_ext && m_brk) begin
                m_ext = 0; m_brk = 0;                // extended break: ignored
            end else if (m_ext) begin
                if (c == 8'hF0) m_brk = 1; else m_ext = 0;
            end else if (m_brk) begin
                model_release(c);
                m_brk = 0;
            end else if (c == 8'hE0) begin
                m_ext = 1;
            end else if (c == 8'hF0) begin
                m_brk = 1;
            end else begin
                model_press(c, wr, ch);
            end
        end
        if (rd) void'(exp_q.pop_front());
        if (wr) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(ch);
                m_count = m_count + 1'b1;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    // ------------------------------------------------------------------ scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("ascii_valid", 32'(ascii_valid), 32'(exp_q.size() > 0));
        check("ascii_out", 32'(ascii_out), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
        check("shift_on", 32'(shift_on), 32'(m_lsh | m_rsh));
        check("caps_on", 32'(caps_on), 32'(m_caps));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("char_count", 32'(char_count), 32'(m_count));
    endtask

    function automatic logic [7:0] got_at(int i);
        return (i < got_q.size()) ? got_q[i] : 8'hFF;
    endfunction

    // ------------------------------------------------------------------ driver tasks
    // Called at a falling edge; drives one cycle and checks after the next edge.
    task automatic cycle(input bit v, input logic [7:0] c, input bit r);
        code_valid  = v;
        code_in     = c;
        ascii_ready = r;
        if (ascii_valid && r) got_q.push_back(ascii_out);
        model_cycle(v, c, r);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [7:0] c);
        cycle(1'b1, c, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
    endtask

    // A byte presented during reset must be ignored
    task automatic do_reset();
        rst         = 1'b1;
        code_valid  = 1'b1;
        code_in     = 8'h1C;
        ascii_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        code_valid = 1'b0;
        model_reset();
        compare_all();
    endtask

    // ------------------------------------------------------------------ stimulus
    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Single press and release of 'a'
        got_q.delete();
        send(8'h1C); send(8'hF0); send(8'h1C);
        idle(2);
        check("t1_nchars", got_q.size(), 1);
        check("t1_char", got_at(0), 8'h61);
        check("t1_count", 32'(char_count), 1);
        send(8'h1C);                       // parser must be back in IDLE
        idle(2);
        check("t1_idle_char", got_at(1), 8'h61);

        // Shift held around one letter
        got_q.delete();
        send(8'h12);
        check("t2_shift_held", 32'(shift_on), 1);
        send(8'h1C); send(8'hF0); send(8'h12);
        check("t2_shift_released", 32'(shift_on), 0);
        send(8'h1C);
        idle(2);
        check("t2_nchars", got_q.size(), 2);
        check("t2_upper", got_at(0), 8'h41);
        check("t2_lower", got_at(1), 8'h61);

        // Caps Lock with typematic repeat, then Shift cancels it
        got_q.delete();
        send(8'h58);
        check("t3_caps_on", 32'(caps_on), 1);
        send(8'h58);
        check("t3_caps_repeat", 32'(caps_on), 1);
        send(8'hF0); send(8'h58); send(8'h12); send(8'h32);
        idle(2);
        check("t3_nchars", got_q.size(), 1);
        check("t3_char", got_at(0), 8'h62);
        send(8'hF0); send(8'h12);
        send(8'h16);                       // caps does not affect digits
        send(8'h12); send(8'h16);          // shifted '1' is '!'
        send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58);
        idle(2);
        check("t3_digit", got_at(1), 8'h31);
        check("t3_bang", got_at(2), 8'h21);

        // Extended keys produce nothing
        got_q.delete();
        send(8'hE0); send(8'h70);
        send(8'hE0); send(8'hF0); send(8'h70);
        send(8'h70);
        idle(2);
        check("t4_nchars", got_q.size(), 1);
        check("t4_char", got_at(0), 8'h30);

        // FIFO overflow, then simultaneous read and write on a full FIFO
        do_reset();
        got_q.delete();
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'h29, 1'b0);
        check("t5_count", 32'(char_count), 8);
        check("t5_overflow", 32'(overflow), 1);
        check("t5_valid", 32'(ascii_valid), 1);
        cycle(1'b1, 8'h29, 1'b1);
        check("t5_rw_count", 32'(char_count), 9);
        check("t5_rw_read", got_q.size(), 1);
        idle(10);
        check("t5_drained", got_q.size(), 9);
        check("t5_last", got_at(8), 8'h20);
        check("t5_empty", 32'(ascii_valid), 0);

        // Typematic repeat of a letter
        do_reset();
        got_q.delete();
        send(8'h1D); send(8'h1D); send(8'h1D);
        send(8'hF0); send(8'h1D); send(8'h1D);
        idle(2);
`ifdef PS2_REPEAT_FILTER_EN
        check("t6_repeat_chars", got_q.size(), 2);
`else
        check("t6_repeat_chars", got_q.size(), 4);
`endif
        check("t6_char", got_at(1), 8'h77);

        // Reset between 0xF0 and its break byte loses the pending prefix
        do_reset();
        got_q.delete();
        send(8'hF0);
        do_reset();
        send(8'h1C);
        idle(2);
        check("t7_nchars", got_q.size(), 1);
        check("t7_char", got_at(0), 8'h61);

        // Randomized traffic with random backpressure and occasional reset
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 9) < 7),
                      pool[$urandom_range(0, 23)],
                      1'($urandom_range(0, 3) != 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
